// File: rtl/image_flow_sequencer_if.sv
// Handshake and strobe bundle between the image flow sequencer and its
// host stream, image buffer, hash engine and reorder engine.
interface image_flow_sequencer_if #(
  parameter int unsigned IDX_W = 16
);
  logic             start;
  logic [IDX_W-1:0] num_images;
  logic             pixel_valid;
  logic             pixel_ready;
  logic [7:0]       pixel_index;
  logic             image_buffer_valid;
  logic             hash_start;
  logic             hash_calc_done;
  logic [IDX_W-1:0] image_header;
  logic             reorder_start;
  logic             new_reference_is_done;
  logic [IDX_W-1:0] count_image;
  logic             finish_reordering;
  logic             busy;
  logic             cfg_err;

  // master: host and engines; slave: the sequencer
  modport master (
    output start, num_images, pixel_valid, hash_calc_done, new_reference_is_done,
    input  pixel_ready, pixel_index, image_buffer_valid, hash_start, image_header,
           reorder_start, count_image, finish_reordering, busy, cfg_err
  );

  modport slave (
    input  start, num_images, pixel_valid, hash_calc_done, new_reference_is_done,
    output pixel_ready, pixel_index, image_buffer_valid, hash_start, image_header,
           reorder_start, count_image, finish_reordering, busy, cfg_err
  );
endinterface

// File: rtl/image_flow_sequencer.sv
// Phase controller for the image reordering accelerator: pixel ingest,
// per-image hash, then the reorder loop. All outputs are registered.
module image_flow_sequencer #(
  parameter int unsigned PIXELS_PER_IMAGE = 256,
  parameter int unsigned IDX_W            = 16
) (
  input logic                   clk,
  input logic                   reset,
  image_flow_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, HASH, REORDER, DONE} state_t;

  localparam logic [7:0]       LAST_PIX = 8'(PIXELS_PER_IMAGE - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] n_lat_q, n_lat_d;
  logic [7:0]       pix_q, pix_d;
  logic [IDX_W-1:0] hdr_q, hdr_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             ibv_q, ibv_d;
  logic             hs_q, hs_d;
  logic             rs_q, rs_d;
  logic             fin_q, fin_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] n_last;
  logic [IDX_W-1:0] cnt_inc;

  assign n_last  = n_lat_q - ONE;
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    n_lat_d = n_lat_q;
    pix_d   = pix_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ibv_d   = 1'b0;
    hs_d    = 1'b0;
    rs_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_lat_d = bus.num_images;
          hdr_d   = '0;
          cnt_d   = '0;
          pix_d   = '0;
          err_d   = 1'b0;
          if (bus.num_images == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (bus.pixel_valid && ready_q) begin
          if (pix_q == LAST_PIX) begin
            pix_d   = '0;
            ibv_d   = 1'b1;
            hs_d    = 1'b1;
            state_d = HASH;
          end else begin
            pix_d = pix_q + 8'd1;
          end
        end
      end

      HASH: begin
        if (bus.hash_calc_done) begin
          if (hdr_q == n_last) begin
            rs_d    = 1'b1;
            state_d = REORDER;
          end else begin
            hdr_d   = hdr_q + ONE;
            state_d = LOAD;
          end
        end
      end

      // a single-image run needs no reorder steps, so it leaves after one cycle
      REORDER: begin
        if (n_lat_q == ONE) begin
          state_d = DONE;
        end else if (bus.new_reference_is_done) begin
          cnt_d = cnt_inc;
          if (cnt_inc == n_last) state_d = DONE;
        end
      end

      DONE: begin
        if (!bus.start) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == LOAD);
    fin_d   = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_lat_q <= '0;
      pix_q   <= '0;
      hdr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      ibv_q   <= 1'b0;
      hs_q    <= 1'b0;
      rs_q    <= 1'b0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_lat_q <= n_lat_d;
      pix_q   <= pix_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      ibv_q   <= ibv_d;
      hs_q    <= hs_d;
      rs_q    <= rs_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.pixel_ready        = ready_q;
  assign bus.pixel_index        = pix_q;
  assign bus.image_buffer_valid = ibv_q;
  assign bus.hash_start         = hs_q;
  assign bus.image_header       = hdr_q;
  assign bus.reorder_start      = rs_q;
  assign bus.count_image        = cnt_q;
  assign bus.finish_reordering  = fin_q;
  assign bus.busy               = busy_q;
  assign bus.cfg_err            = err_q;

endmodule

// File: tb/tb_image_flow_sequencer.sv
// Self-checking bench for image_flow_sequencer: expected image headers are
// queued as the last beat of each image is driven and popped on image_buffer_valid.
module tb_image_flow_sequencer;

  localparam int unsigned PIX = 256;
  localparam int unsigned IW  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  image_flow_sequencer_if #(.IDX_W(IW)) bus ();

  image_flow_sequencer #(
    .PIXELS_PER_IMAGE(PIX),
    .IDX_W           (IW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] mon_e;
  int   rs_seen      = 0;
  bit   hash_auto_en = 1'b0;
  int   hash_delay   = 3;
  int   hcnt         = 0;
  logic auto_done    = 1'b0;
  logic spur_done    = 1'b0;

  assign bus.hash_calc_done = auto_done | spur_done;

  // Scoreboard monitor for buffer strobes
  always @(negedge clk) begin
    if (bus.image_buffer_valid === 1'b1 || bus.hash_start === 1'b1) begin
      total++;
      if (bus.hash_start !== bus.image_buffer_valid || bus.pixel_ready !== 1'b0) begin
        bad++;
        $display("FAIL buf_strobes: ibv=%b hs=%b ready=%b, required ibv=1 hs=1 ready=0",
                 bus.image_buffer_valid, bus.hash_start, bus.pixel_ready);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL buf_unexpected: pulse with header=%0d, required no pulse", bus.image_header);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.image_header !== mon_e) begin
          bad++;
          $display("FAIL buf_header: got %0d, required %0d", bus.image_header, mon_e);
        end
      end
    end
    if (bus.reorder_start === 1'b1) rs_seen++;
  end

  // Hash engine model: done hash_delay cycles after hash_start (0 = same cycle)
  always @(negedge clk) begin
    auto_done = 1'b0;
    if (hash_auto_en) begin
      if (bus.hash_start === 1'b1) begin
        if (hash_delay == 0) auto_done = 1'b1;
        else hcnt = hash_delay;
      end else if (hcnt > 0) begin
        hcnt--;
        if (hcnt == 0) auto_done = 1'b1;
      end
    end
  end

  task automatic start_run(input logic [IW-1:0] n);
    @(negedge clk);
    bus.num_images = n;
    bus.start      = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || bus.cfg_err !== 1'b0 || bus.image_header !== '0 ||
        bus.count_image !== '0 || bus.pixel_index !== 8'd0 || bus.pixel_ready !== 1'b1) begin
      bad++;
      $display("FAIL run_start: busy=%b err=%b hdr=%0d cnt=%0d idx=%0d ready=%b, required 1 0 0 0 0 1",
               bus.busy, bus.cfg_err, bus.image_header, bus.count_image, bus.pixel_index, bus.pixel_ready);
    end
  endtask

  task automatic feed_image(input int nbeats, input bit sparse, input bit spurious,
                            input logic [IW-1:0] hdr);
    int acc = 0;
    int cyc = 0;
    bit v;
    bit acc_now;
    while (acc < nbeats && cyc < 4000) begin
      @(negedge clk);
      if (bus.pixel_ready === 1'b1) begin
        total++;
        if (bus.pixel_index !== 8'(acc) || bus.image_header !== hdr) begin
          bad++;
          $display("FAIL pix_index: idx=%0d hdr=%0d, required idx=%0d hdr=%0d",
                   bus.pixel_index, bus.image_header, acc % 256, hdr);
        end
      end
      v = sparse ? ((cyc % 2) == 0) : 1'b1;
      bus.pixel_valid = v;
      acc_now = v && (bus.pixel_ready === 1'b1);
      if (acc_now) begin
        acc++;
        if (acc == int'(PIX)) exp_q.push_back(hdr);
      end
      spur_done = spurious && (bus.pixel_ready === 1'b1) && (acc < int'(PIX)) && ((cyc % 5) == 1);
      cyc++;
    end
    if (acc < nbeats) begin
      total++;
      bad++;
      $display("FAIL feed_timeout: accepted %0d beats, required %0d", acc, nbeats);
    end
  endtask

  task automatic run_images(input int n, input bit sparse, input bit spurious);
    for (int k = 0; k < n; k++) feed_image(PIX, sparse, spurious, IW'(k));
  endtask

  task automatic wait_reorder(input logic [IW-1:0] exp_hdr);
    int cyc = 0;
    bit ok = 1'b0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      bus.pixel_valid = 1'b0;
      spur_done = 1'b0;
      if (bus.reorder_start === 1'b1) ok = 1'b1;
      cyc++;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL reorder_timeout: reorder_start not seen, required within 200 cycles");
    end else if (bus.image_header !== exp_hdr || bus.count_image !== '0 ||
                 bus.finish_reordering !== 1'b0 || bus.pixel_ready !== 1'b0) begin
      bad++;
      $display("FAIL reorder_entry: hdr=%0d cnt=%0d fin=%b ready=%b, required hdr=%0d 0 0 0",
               bus.image_header, bus.count_image, bus.finish_reordering, bus.pixel_ready, exp_hdr);
    end
  endtask

  task automatic reorder_steps(input int nsteps, input bit coincident);
    bit exp_fin;
    for (int i = 1; i <= nsteps; i++) begin
      if (i > 1 || !coincident) @(negedge clk);
      bus.new_reference_is_done = 1'b1;
      @(negedge clk);
      bus.new_reference_is_done = 1'b0;
      exp_fin = (i == nsteps);
      total++;
      if (bus.count_image !== IW'(i) || bus.finish_reordering !== exp_fin) begin
        bad++;
        $display("FAIL reorder_step: cnt=%0d fin=%b, required cnt=%0d fin=%b",
                 bus.count_image, bus.finish_reordering, i, exp_fin);
      end
    end
  endtask

  task automatic finish_done(input logic [IW-1:0] exp_cnt, input logic exp_err);
    total++;
    if (bus.finish_reordering !== 1'b1 || bus.busy !== 1'b1 ||
        bus.count_image !== exp_cnt || bus.cfg_err !== exp_err) begin
      bad++;
      $display("FAIL done_state: fin=%b busy=%b cnt=%0d err=%b, required 1 1 %0d %b",
               bus.finish_reordering, bus.busy, bus.count_image, bus.cfg_err, exp_cnt, exp_err);
    end
    bus.start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.finish_reordering !== 1'b0 || bus.busy !== 1'b0 ||
        bus.count_image !== exp_cnt || bus.cfg_err !== exp_err) begin
      bad++;
      $display("FAIL done_exit: fin=%b busy=%b cnt=%0d err=%b, required 0 0 %0d %b",
               bus.finish_reordering, bus.busy, bus.count_image, bus.cfg_err, exp_cnt, exp_err);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL buf_missing: %0d images never signalled, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({bus.pixel_ready, bus.pixel_index, bus.image_buffer_valid, bus.hash_start,
         bus.image_header, bus.reorder_start, bus.count_image, bus.finish_reordering,
         bus.busy, bus.cfg_err} !== 47'd0) begin
      bad++;
      $display("FAIL %s: outputs ready=%b idx=%0d ibv=%b hs=%b hdr=%0d rs=%b cnt=%0d fin=%b busy=%b err=%b, required all 0",
               tag, bus.pixel_ready, bus.pixel_index, bus.image_buffer_valid, bus.hash_start,
               bus.image_header, bus.reorder_start, bus.count_image, bus.finish_reordering,
               bus.busy, bus.cfg_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_full_run();
    hash_auto_en = 1'b1;
    hash_delay   = 3;
    rs_seen      = 0;
    start_run(16'd10);
    run_images(10, 1'b0, 1'b0);
    wait_reorder(16'd9);
    reorder_steps(9, 1'b0);
    total++;
    if (rs_seen != 1) begin
      bad++;
      $display("FAIL reorder_start_count: got %0d pulses, required 1", rs_seen);
    end
    finish_done(16'd9, 1'b0);
  endtask

  task automatic test_single_image();
    start_run(16'd1);
    run_images(1, 1'b0, 1'b0);
    wait_reorder(16'd0);
    @(negedge clk);
    finish_done(16'd0, 1'b0);
  endtask

  task automatic test_zero_images();
    @(negedge clk);
    bus.num_images = '0;
    bus.start      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (bus.cfg_err !== 1'b1 || bus.finish_reordering !== 1'b1 || bus.pixel_ready !== 1'b0) begin
        bad++;
        $display("FAIL zero_images: err=%b fin=%b ready=%b, required 1 1 0",
                 bus.cfg_err, bus.finish_reordering, bus.pixel_ready);
      end
    end
    finish_done(16'd0, 1'b1);
  endtask

  task automatic test_sparse_spurious();
    start_run(16'd3);
    bus.start = 1'b0;
    run_images(3, 1'b1, 1'b1);
    wait_reorder(16'd2);
    reorder_steps(2, 1'b0);
    finish_done(16'd2, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    start_run(16'd6);
    run_images(4, 1'b0, 1'b0);
    feed_image(100, 1'b0, 1'b0, 16'd4);
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    total++;
    if (bus.pixel_index !== 8'd100 || bus.image_header !== 16'd4) begin
      bad++;
      $display("FAIL mid_load_pos: idx=%0d hdr=%0d, required 100 4", bus.pixel_index, bus.image_header);
    end
    #2 reset = 1'b1;
    bus.start = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_all_zero("after_async_reset");
    start_run(16'd2);
    run_images(2, 1'b0, 1'b0);
    wait_reorder(16'd1);
    reorder_steps(1, 1'b0);
    finish_done(16'd1, 1'b0);
  endtask

  task automatic test_coincident();
    hash_delay = 0;
    start_run(16'd2);
    feed_image(PIX, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.image_header !== 16'd1 || bus.pixel_ready !== 1'b1) begin
      bad++;
      $display("FAIL hash_coincident: hdr=%0d ready=%b, required 1 1", bus.image_header, bus.pixel_ready);
    end
    feed_image(PIX, 1'b0, 1'b0, 16'd1);
    wait_reorder(16'd1);
    reorder_steps(1, 1'b1);
    finish_done(16'd1, 1'b0);
  endtask

  initial begin
    reset                     = 1'b1;
    bus.start                 = 1'b0;
    bus.num_images            = '0;
    bus.pixel_valid           = 1'b0;
    bus.new_reference_is_done = 1'b0;
    test_reset();
    test_full_run();
    test_single_image();
    test_zero_images();
    test_sparse_spurious();
    test_reset_mid_load();
    test_coincident();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_flow_sequencer.md
Name: image_flow_sequencer

Overview:
- Top-level phase controller for the image reordering accelerator.
- Sequences the three phases of a run: pixel ingest into the image buffer, hash calculation per image, and the reordering loop.
- Drives the start and valid strobes seen by the buffer, hash and reorder datapaths, and counts images and reorder steps.
- Sits between the host-side pixel stream and the hash and reorder engines inside top.

Parameters:
- PIXELS_PER_IMAGE, 256, pixel beats per image; must be at least 2.
- IDX_W, 16, width of image counts and indices.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level run request.
- num_images  in  IDX_W  images in the run; latched on run start.
- pixel_valid  in  1  pixel beat offered by host.
- pixel_ready  out  1  sequencer accepts a pixel beat this cycle.
- pixel_index  out  8  pixel position within the current image; wraps 255 -> 0.
- image_buffer_valid  out  1  one-cycle pulse: current image fully buffered.
- hash_start  out  1  one-cycle pulse to the hash engine; coincident with image_buffer_valid.
- hash_calc_done  in  1  hash engine finished the current image.
- image_header  out  IDX_W  index of the image being loaded or hashed.
- reorder_start  out  1  one-cycle pulse at reorder phase entry.
- new_reference_is_done  in  1  reorder engine produced one new reference.
- count_image  out  IDX_W  reorder steps completed.
- finish_reordering  out  1  run complete; level.
- busy  out  1  high in any state except IDLE.
- cfg_err  out  1  sticky; set when a run starts with num_images == 0.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- FSM states: IDLE, LOAD, HASH, REORDER, DONE.
- Run start, IDLE with start == 1:
  - Latch num_images into n_lat.
  - Clear image_header, count_image and cfg_err.
  - If num_images == 0: set cfg_err and go to DONE.
  - Otherwise go to LOAD.
- LOAD:
  - pixel_ready = 1.
  - A beat is accepted when pixel_valid && pixel_ready; pixel_index increments on each accepted beat.
  - On acceptance of beat PIXELS_PER_IMAGE-1:
    - pixel_index returns to 0.
    - Next cycle: image_buffer_valid = 1 and hash_start = 1 (one cycle each), state HASH, pixel_ready = 0.
  - Gaps in pixel_valid stall the count; no timeout.
- HASH:
  - pixel_valid is ignored.
  - On hash_calc_done == 1:
    - If image_header == n_lat-1: go to REORDER; image_header holds its value.
    - Otherwise image_header increments and the FSM returns to LOAD the next cycle.
  - hash_calc_done asserted outside HASH is ignored.
  - A hash_calc_done in the same cycle as hash_start is legal and is honoured.
- REORDER:
  - reorder_start = 1 on the first cycle in this state only.
  - Each new_reference_is_done pulse increments count_image.
  - When count_image reaches n_lat-1, go to DONE on that same edge.
  - With n_lat == 1, no steps are needed: go to DONE the cycle after entry. reorder_start is still pulsed.
  - A new_reference_is_done on the reorder_start cycle counts.
- DONE:
  - finish_reordering = 1; count_image and image_header hold.
  - Remain in DONE while start == 1.
  - When start == 0, go to IDLE the next cycle and clear finish_reordering.
- Deasserting start mid-run has no effect; the run completes. Only reset aborts a run.
- Asynchronous reset during any state: immediate return to IDLE with all outputs 0. pixel_ready drops without waiting for a clock edge.
- Counter arithmetic is unsigned IDX_W bits. n_lat-1 is computed only when n_lat >= 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset held 2 cycles, then start=1 with num_images=10. Drive 256 continuous beats and return hash_calc_done 3 cycles after each hash_start.
   -> 10 image_buffer_valid pulses with image_header 0..9; pixel_ready low during HASH; reorder_start once. After 9 new_reference_is_done pulses: count_image=9 and finish_reordering=1.
2. num_images=1.
   -> One load/hash pass, then reorder_start; finish_reordering rises 1 cycle later with count_image=0.
3. num_images=0 with start=1.
   -> No pixel_ready; cfg_err=1 and finish_reordering=1 the next cycle. start=0 returns to IDLE with finish cleared and cfg_err held.
4. pixel_valid toggled every other cycle, plus spurious hash_calc_done pulses during LOAD.
   -> image_buffer_valid only after exactly 256 accepted beats; the spurious done pulses do not advance image_header.
5. Reset asserted mid-LOAD of image 4 (pixel_index=100), then a new run with num_images=2.
   -> All outputs 0 immediately on reset. The new run starts at image_header=0 and pixel_index=0.
6. hash_calc_done coincident with hash_start, and new_reference_is_done coincident with reorder_start.
   -> Both are honoured: image advance and count_image=1 on the following cycle.
